// File: rtl/wid_byte_packer.sv
//------------------------------------------------------------------------------
// wid_byte_packer
//
// Packs a stream of bytes into OUT_BYTES-wide little-endian words. Byte k of a
// word lands at bits [8k+7:8k]. A byte flagged with in_last closes the current
// word early. Lanes that were never written are zero, and out_keep marks the
// filled lanes as a contiguous low mask.
//
// Parameters
//   OUT_BYTES  bytes per output word (2..16)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   byte present on in_data
//   in_ready   packer can take a byte this cycle
//   in_data    byte payload
//   in_last    accepted byte ends a packet
//   out_valid  output register holds a word
//   out_ready  downstream takes the word this cycle
//   out_data   assembled word
//   out_keep   per-lane valid mask
//   out_last   word ends a packet
//------------------------------------------------------------------------------
module wid_byte_packer #(
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last
);

    localparam int CW = (OUT_BYTES > 2) ? $clog2(OUT_BYTES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(OUT_BYTES - 1);

    // Occupancy of the single-entry output register
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } occ_t;

    occ_t state_q;
    occ_t state_d;

    logic [8*OUT_BYTES-1:0] acc;
    logic [8*OUT_BYTES-1:0] acc_d;
    logic [CW-1:0]          cnt;
    logic [8*OUT_BYTES-1:0] word_d;
    logic [OUT_BYTES-1:0]   keep_d;

    logic accept;
    logic complete;

    // A held word blocks input until downstream takes it; a word being taken
    // this cycle frees the slot, so a new word may load in the same cycle.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (in_last || (cnt == LAST_LANE));

    // Build both the next partial accumulator and the completed word. The
    // completed word takes acc with lane cnt replaced by the incoming byte and
    // every lane above cnt cleared, so a short packet never carries stale data.
    always_comb begin
        acc_d  = acc;
        word_d = acc;
        keep_d = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (CW'(i) == cnt) begin
                acc_d[8*i +: 8]  = in_data;
                word_d[8*i +: 8] = in_data;
            end
            if (CW'(i) > cnt) begin
                word_d[8*i +: 8] = 8'h00;
            end
            keep_d[i] = (CW'(i) <= cnt);
        end
    end

    // Next occupancy: a completing byte always fills the register; otherwise
    // a taken word empties it.
    always_comb begin
        state_d = state_q;
        if (complete) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Lane accumulator and counter. Completion restarts both at lane 0, and a
    // reset throws away any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (complete) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_d;
            cnt <= cnt + CW'(1);
        end
    end

    // Output payload register. It only changes when a word completes, which
    // keeps the payload stable for as long as downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else if (complete) begin
            out_data <= word_d;
            out_keep <= keep_d;
            out_last <= in_last;
        end
    end

endmodule

// File: tb/tb_wid_byte_packer.sv
//------------------------------------------------------------------------------
// tb_wid_byte_packer
//
// Drives directed packets followed by a randomized byte stream with random
// backpressure. A reference model built from byte queues predicts each word,
// its keep mask and when the output register should be occupied.
//------------------------------------------------------------------------------
module tb_wid_byte_packer;

    localparam int N = 4;

    typedef struct {
        logic [8*N-1:0] data;
        logic [N-1:0]   keep;
        logic           last;
    } word_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     in_data = 8'h00;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [8*N-1:0] out_data;
    logic [N-1:0]   out_keep;
    logic           out_last;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: bytes of the word being gathered, and words
    // completed but not yet taken by downstream.
    logic [7:0] partial[$];
    word_t      pending[$];

    wid_byte_packer #(.OUT_BYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // One comparison with failure accounting
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs with the model before the coming edge
    task automatic checkOutput();
        logic exp_valid;
        exp_valid = (pending.size() > 0);
        check("out_valid", 128'(out_valid), 128'(exp_valid));
        check("in_ready", 128'(in_ready), 128'(!exp_valid || out_ready));
        if (exp_valid) begin
            check("out_data", 128'(out_data), 128'(pending[0].data));
            check("out_keep", 128'(out_keep), 128'(pending[0].keep));
            check("out_last", 128'(out_last), 128'(pending[0].last));
        end
    endtask

    // Advance the model across one rising edge
    task automatic modelEdge();
        logic  exp_valid;
        logic  taken;
        logic  accepted;
        word_t w;
        exp_valid = (pending.size() > 0);
        taken     = exp_valid && out_ready;
        accepted  = in_valid && (!exp_valid || out_ready);
        if (taken) begin
            void'(pending.pop_front());
        end
        if (accepted) begin
            partial.push_back(in_data);
            if (in_last || (partial.size() == N)) begin
                w.data = '0;
                for (int k = 0; k < partial.size(); k++) begin
                    w.data[8*k +: 8] = partial[k];
                end
                w.keep = N'((1 << partial.size()) - 1);
                w.last = in_last;
                pending.push_back(w);
                partial.delete();
            end
        end
    endtask

    // Drive one cycle: set inputs on the falling edge, check, then step
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        checkOutput();
        modelEdge();
    endtask

    // Check the cleared state while reset is held
    task automatic checkReset();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_keep", 128'(out_keep), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [7:0] b;
        logic       v;
        logic       l;
        logic       r;

        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Full word
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("full_word_const", 128'(dut.out_data), 128'(32'h44332211));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Partial flush
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("partial_keep_const", 128'(out_keep), 128'(4'h3));

        // Single-byte packet
        applyStimulus(1'b1, 8'h5C, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming eight bytes back-to-back
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("stream_second_const", 128'(out_data), 128'(32'h08070605));

        // Last flag on the final lane
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC4, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure with a byte waiting
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h88, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("bp_next_word_const", 128'(out_data), 128'(32'h88776655));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-word
        applyStimulus(1'b1, 8'hDE, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hAD, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkReset();
        partial.delete();
        pending.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_word_const", 128'(out_data), 128'(32'h04030201));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            b = 8'($urandom);
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) < 2);
            r = ($urandom_range(0, 9) < 6);
            applyStimulus(v, b, l, r);
        end

        // Drain whatever is left
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
